// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the EX stage.
//   Executes MULTU/MULT/DIVU/DIV with a radix-2 shift-add multiplier and a
//   restoring divider over operand magnitudes, then applies sign correction.
//   Result layout is {hi, lo}: MUL -> {prod_hi, prod_lo}, DIV -> {rem, quo}.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start_i    request, sampled only in IDLE
//   op_i       00=MULTU 01=MULT 10=DIVU 11=DIV, sampled with start_i
//   a_i, b_i   multiplicand/dividend, multiplier/divisor
//   cancel_i   abort; dominates start_i
//   busy_o     unit not idle (pipeline stall)
//   ready_o    one-cycle pulse, result_o valid
//   result_o   2*WIDTH result, held until the next result is formed
//   div0_o     (only with MDU_DIV0_FLAG_EN) high in the DONE cycle of a
//              divide whose divisor was zero
//
// Build option: define MDU_DIV0_FLAG_EN to add the div0_o port.

module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
`ifdef MDU_DIV0_FLAG_EN
  output logic               div0_o,
`endif
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic               quo_neg_q;
  logic               rem_neg_q;
  logic [WIDTH-1:0]   b_q;      // divisor / multiplicand magnitude
  logic [WIDTH-1:0]   rem_q;    // remainder / product high half
  logic [WIDTH-1:0]   lo_q;     // dividend->quotient / multiplier->product low half
  logic               busy_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;
`ifdef MDU_DIV0_FLAG_EN
  logic               div0_q;
`endif

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   lo_d;
  logic               is_div;
  logic               div0;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result_d;
  logic               unused_guard;

  always_comb begin
    a_mag = (op_i[0] && a_i[WIDTH-1]) ? '0 - a_i : a_i;
    b_mag = (op_i[0] && b_i[WIDTH-1]) ? '0 - b_i : b_i;
  end

  // One radix-2 step. The divider's shifted partial remainder carries one
  // guard bit; since rem < divisor before the step, the new remainder always
  // fits back into WIDTH bits.
  always_comb begin
    is_div   = op_q[1];
    mul_sum  = lo_q[0] ? ({1'b0, rem_q} + {1'b0, b_q}) : {1'b0, rem_q};
    div_sh   = {rem_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh - {1'b0, b_q};
    if (is_div) begin
      rem_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      rem_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign unused_guard = div_diff[WIDTH];

  // Sign correction. With a zero divisor every step subtracts nothing, so the
  // remainder ends as |a|; restoring the dividend sign yields a_i exactly,
  // while the quotient is forced to all-ones.
  always_comb begin
    div0     = is_div && (b_q == '0);
    prod     = {rem_q, lo_q};
    quo_fix  = div0 ? '1 : (quo_neg_q ? '0 - lo_q : lo_q);
    rem_fix  = rem_neg_q ? '0 - rem_q : rem_q;
    result_d = is_div ? {rem_fix, quo_fix} : (quo_neg_q ? '0 - prod : prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_q       <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
`ifdef MDU_DIV0_FLAG_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !cancel_i) begin
            op_q      <= op_i;
            quo_neg_q <= op_i[0] & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rem_neg_q <= op_i[0] & a_i[WIDTH-1];
            b_q       <= b_mag;
            rem_q     <= '0;
            lo_q      <= a_mag;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (cancel_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            result_q <= result_d;
            ready_q  <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= div0;
`endif
            state_q  <= S_DONE;
          end
        end
        default: begin
          ready_q <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
          div0_q  <= 1'b0;
`endif
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;
`ifdef MDU_DIV0_FLAG_EN
  assign div0_o   = div0_q;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32).
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.

module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
`ifdef MDU_DIV0_FLAG_EN
  logic        div0_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ready_cnt = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  mdu_iter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
`ifdef MDU_DIV0_FLAG_EN
    .div0_o   (div0_o),
`endif
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which ready_o was high (old value seen at each edge).
  always @(posedge clk) if (ready_o) ready_cnt <= ready_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the unit idle; returns at a falling edge
  // one cycle after the ready pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic div0_exp);
    int cycles;
    start_i  = 1'b1;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    cancel_i = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!ready_o && cycles < 100);
    check({tag, ".lat"}, 64'(cycles), 64'd33);
    check({tag, ".res"}, result_o, exp);
`ifdef MDU_DIV0_FLAG_EN
    check({tag, ".div0"}, 64'(div0_o), 64'(div0_exp));
`else
    if (div0_exp) begin end
`endif
    @(negedge clk);
    check({tag, ".idle"}, {62'd0, busy_o, ready_o}, 64'd0);
  endtask

  initial begin
    int rc;
    int cycles;
    rst      = 1'b0;
    start_i  = 1'b0;
    op_i     = 2'b00;
    a_i      = '0;
    b_i      = '0;
    cancel_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", {busy_o, ready_o, result_o}, 66'd0);
    rst = 1'b1;
    @(negedge clk);

    // Multiply cases
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b0);
    run_op("mult_nn",   OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFD, 64'h00000000_00000009, 1'b0);

    // Divide cases
    run_op("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("div_7_m2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_op("divu_z",    OP_DIVU,  32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b1);
    run_op("div_z_neg", OP_DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1'b1);
    run_op("div_minm1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_op("divu_7_9",  OP_DIVU,  32'd7,        32'd9,        64'h00000007_00000000, 1'b0);

    // Cancel in IDLE blocks a simultaneous start
    start_i  = 1'b1;
    cancel_i = 1'b1;
    op_i     = OP_MULTU;
    a_i      = 32'd3;
    b_i      = 32'd5;
    @(negedge clk);
    check("cancel_idle.busy", 64'(busy_o), 64'd0);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    @(negedge clk);

    // Cancel 10 cycles into RUN, then immediately start a new divide
    rc = ready_cnt;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("cancel.busy_run", 64'(busy_o), 64'd1);
    cancel_i = 1'b1;
    @(negedge clk);
    check("cancel.state", {62'd0, busy_o, ready_o}, 64'd0);
    check("cancel.hold", result_o, 64'h00000007_00000000);
    run_op("divu_9_4", OP_DIVU, 32'd9, 32'd4, 64'h00000001_00000002, 1'b0);
    check("cancel.readies", 64'(ready_cnt - rc), 64'd1);

    // Asynchronous reset in the middle of RUN
    start_i = 1'b1;
    op_i    = OP_MULTU;
    a_i     = 32'd11;
    b_i     = 32'd13;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_mid", {busy_o, ready_o, result_o}, 66'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_after", {busy_o, ready_o, result_o}, 66'd0);

    // start_i held through busy and DONE gives exactly one ready pulse
    rc = ready_cnt;
    start_i = 1'b1;
    op_i    = OP_MULTU;
    a_i     = 32'd2;
    b_i     = 32'd3;
    cycles  = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ready_o && cycles < 100);
    check("hold.res", result_o, 64'd6);
    check("hold.busy_done", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("hold.readies", 64'(ready_cnt - rc), 64'd1);
    check("hold.idle", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
